sqrt_iter_ctrl: RTL and testbench
=================================

SQRT_ITER_CTRL -- requirements
Module: sqrt_iter_ctrl

Interface
REQ-001 SHALL have parameter ITER_COUNT, default 3, number of Newton iterations per operand (legal 1..15).
REQ-002 SHALL have parameter CNT_W, default 4, width of the iteration counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1, in_data input 32: IEEE-754 single operand handshake.
REQ-006 SHALL have ports recip_start output 1, recip_den output 32, recip_valid input 1, recip_res input 32: reciprocal unit request and response.
REQ-007 SHALL have ports step_en output 1, step_s output 32, step_x output 32, step_recip output 32, step_res input 32: Newton step datapath with 1-cycle registered result.
REQ-008 SHALL have ports out_valid output 1, out_ready input 1, out_data output 32, out_flag output 2: result handshake (flag 00 normal, 01 zero, 10 invalid).

Function
REQ-009 SHALL implement states IDLE, SEED, RECIP, STEP, STEP_WAIT, DONE.
REQ-010 in_ready SHALL be 1 only in IDLE; a transfer occurs when in_valid && in_ready, latching in_data into operand register s.
REQ-011 IDLE->SEED on transfer; SEED lasts 1 cycle, loads x = {0, ((e-127)>>>1)+127, mantissa of s} (arithmetic shift), and loads the counter with ITER_COUNT.
REQ-012 SEED->RECIP; recip_start SHALL pulse high for exactly the first RECIP cycle, with recip_den = x.
REQ-013 RECIP SHALL hold until recip_valid=1; recip_res is then captured into register r and the FSM moves to STEP.
REQ-014 STEP SHALL assert step_en for one cycle with step_s = s, step_x = x, step_recip = r; STEP->STEP_WAIT unconditionally.
REQ-015 STEP_WAIT SHALL load x = step_res, decrement the counter, go to DONE if the counter reaches 0, else to RECIP.
REQ-016 With a reciprocal latency of L cycles (recip_valid L cycles after recip_start), out_valid SHALL rise 2 + ITER_COUNT*(L+3) cycles after the transfer cycle.
REQ-017 DONE SHALL drive out_valid=1, out_data=x, out_flag stable until out_ready=1, then go to IDLE; in_ready rises the following cycle.
REQ-018 recip_valid outside RECIP and step_res outside STEP_WAIT SHALL be ignored.
REQ-019 recip_den, step_s, step_x, step_recip SHALL be held stable whenever the corresponding strobe is low.
REQ-020 in_valid while busy SHALL be ignored (no latch, no state change).

Reset
REQ-021 On rst=1 at a clock edge: state=IDLE, out_valid=0, recip_start=0, step_en=0, out_data=0, out_flag=00, counter=0, s/x/r=0.
REQ-022 rst mid-operation SHALL abort the operand; any later recip_valid/step_res is ignored and no out_valid is produced for it.
REQ-023 rst SHALL override a simultaneous in_valid/out_ready handshake; in_ready=1 from the first cycle after reset deasserts.

Configuration
REQ-024 Macro SQRT_ITER_CTRL_BYPASS_EN defined: in SEED, operands are classified and bypass the iterations, going SEED->DONE directly.
REQ-025 With bypass: exponent 0 (zero/denormal) -> out_data = {sign,31'b0}, flag 01; sign 1 nonzero or NaN -> 0x7FC00000, flag 10; +Inf -> 0x7F800000, flag 00; bypass out_valid rises 2 cycles after transfer.
REQ-026 Macro undefined: all operands run ITER_COUNT iterations, out_flag is always 00, no classification logic is synthesized.

Verification
REQ-027 ITER_COUNT=3, L=2, in_data=0x41800000 (16.0), step model exact -> out_valid at cycle 17, out_data=0x40800000, flag 00.
REQ-028 out_ready held 0 for 5 cycles in DONE -> out_valid, out_data, out_flag stable; in_ready stays 0; in_valid pulses ignored.
REQ-029 rst asserted in the second RECIP cycle, recip_valid arrives afterward -> stays IDLE, no out_valid, no recip_start, next operand completes normally.
REQ-030 BYPASS_EN defined: 0x80000000 -> out_data 0x80000000 flag 01 at cycle 2; 0xC0000000 -> 0x7FC00000 flag 10; 0x7F800000 -> 0x7F800000 flag 00.
REQ-031 BYPASS_EN undefined: 0xC0000000 -> full iteration sequence, flag 00, recip_start pulses exactly ITER_COUNT times.
REQ-032 Back-to-back: in_valid held 1 with out_ready=1 -> exactly one in_ready cycle per result, results in order, no operand lost or duplicated.

Source files
------------

// File: rtl/sqrt_iter_ctrl.sv
// Square-root sequencer: seeds x from the operand exponent, then runs ITER_COUNT Newton
//   rounds, each a reciprocal request followed by one step on an external datapath.
// Latency: 2 + ITER_COUNT*(L+3) cycles from transfer to out_valid (L = reciprocal latency).
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
// Optional macro SQRT_ITER_CTRL_BYPASS_EN: classify zero/negative/NaN/Inf in SEED and skip
//   the iterations (out_valid 2 cycles after transfer).
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_data operand handshake;
//   recip_start/recip_den/recip_valid/recip_res reciprocal unit; step_en/step_s/step_x/
//   step_recip/step_res Newton step datapath; out_valid/out_ready/out_data/out_flag result
//   (flag 00 normal, 01 zero, 10 invalid).
module sqrt_iter_ctrl #(
  parameter int ITER_COUNT = 3,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        recip_start,
  output logic [31:0] recip_den,
  input  logic        recip_valid,
  input  logic [31:0] recip_res,
  output logic        step_en,
  output logic [31:0] step_s,
  output logic [31:0] step_x,
  output logic [31:0] step_recip,
  input  logic [31:0] step_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_flag
);

  typedef enum logic [2:0] {IDLE, SEED, RECIP, STEP, STEP_WAIT, DONE} state_t;

  state_t           state, state_nxt;
  logic [31:0]      s_q, x_q, r_q, x_nxt;
  logic [CNT_W-1:0] cnt_q;

  // Seed: halve the unbiased exponent (arithmetic shift keeps negative exponents
  // rounding toward -inf) and re-bias; mantissa is reused as-is.
  logic [8:0]  exp_unb, exp_half;
  logic [7:0]  seed_exp;
  logic [31:0] seed_x;

  always_comb begin
    exp_unb  = {1'b0, s_q[30:23]} - 9'd127;
    exp_half = $signed(exp_unb) >>> 1;
    seed_exp = 8'(exp_half + 9'd127);
    seed_x   = {1'b0, seed_exp, s_q[22:0]};
  end

`ifdef SQRT_ITER_CTRL_BYPASS_EN
  logic        byp_hit;
  logic [31:0] byp_x;
  logic [1:0]  byp_flag;
  logic [1:0]  flag_q;

  // Zero/denormal checked first so that -0 reports as zero, not invalid.
  always_comb begin
    byp_hit  = 1'b0;
    byp_x    = 32'h0000_0000;
    byp_flag = 2'b00;
    if (s_q[30:23] == 8'h00) begin
      byp_hit  = 1'b1;
      byp_x    = {s_q[31], 31'b0};
      byp_flag = 2'b01;
    end else if (s_q[31] || (s_q[30:23] == 8'hFF && s_q[22:0] != 23'd0)) begin
      byp_hit  = 1'b1;
      byp_x    = 32'h7FC0_0000;
      byp_flag = 2'b10;
    end else if (s_q[30:23] == 8'hFF) begin
      byp_hit  = 1'b1;
      byp_x    = 32'h7F80_0000;
      byp_flag = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                flag_q <= 2'b00;
    else if (state == SEED) flag_q <= byp_flag;
  end

  assign out_flag = flag_q;
`else
  assign out_flag = 2'b00;
`endif

  always_comb begin
    state_nxt = state;
    x_nxt     = x_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SEED;
      end
      SEED: begin
        x_nxt     = seed_x;
        state_nxt = RECIP;
`ifdef SQRT_ITER_CTRL_BYPASS_EN
        if (byp_hit) begin
          x_nxt     = byp_x;
          state_nxt = DONE;
        end
`endif
      end
      RECIP: begin
        if (recip_valid) state_nxt = STEP;
      end
      STEP: state_nxt = STEP_WAIT;
      STEP_WAIT: begin
        x_nxt     = step_res;
        state_nxt = (cnt_q == CNT_W'(1)) ? DONE : RECIP;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      s_q         <= '0;
      x_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      recip_start <= 1'b0;
      recip_den   <= '0;
      step_en     <= 1'b0;
      step_s      <= '0;
      step_x      <= '0;
    end else begin
      state <= state_nxt;
      x_q   <= x_nxt;
      if (state == IDLE && in_valid) s_q <= in_data;
      if (state == SEED)      cnt_q <= CNT_W'(ITER_COUNT);
      if (state == STEP_WAIT) cnt_q <= cnt_q - CNT_W'(1);
      // Strobes are registered so they sit exactly on the first RECIP / the STEP cycle;
      // their data registers only load alongside the strobe and hold otherwise.
      recip_start <= (state_nxt == RECIP) && (state != RECIP);
      if ((state_nxt == RECIP) && (state != RECIP)) recip_den <= x_nxt;
      step_en <= (state == RECIP) && recip_valid;
      if (state == RECIP && recip_valid) begin
        r_q    <= recip_res;
        step_s <= s_q;
        step_x <= x_q;
      end
    end
  end

  // r only changes on the edge that raises step_en, so it is stable while the strobe is low.
  assign step_recip = r_q;
  assign out_data   = x_q;

endmodule

// File: tb/tb_sqrt_iter_ctrl.sv
// Directed bench for sqrt_iter_ctrl: reciprocal unit with latency L=2 returning ~den,
// step datapath returning x (16.0 operand) or x+1 (others) plus a term that is zero only
// when step_recip matches the reciprocal of step_x. Build with SQRT_ITER_CTRL_BYPASS_EN to
// exercise the classification path.
module tb_sqrt_iter_ctrl;
  localparam int L = 2;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        recip_start, recip_valid;
  logic [31:0] recip_den, recip_res;
  logic        step_en;
  logic [31:0] step_s, step_x, step_recip, step_res;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_flag;

  int errors = 0;
  int checks = 0;
  int rs_cnt = 0;
  logic [31:0] first_den = '0;
  int pend = 0;
  logic [31:0] den_l = '0;
  bit step_hold = 0;

  sqrt_iter_ctrl #(.ITER_COUNT(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .recip_start(recip_start), .recip_den(recip_den),
    .recip_valid(recip_valid), .recip_res(recip_res),
    .step_en(step_en), .step_s(step_s), .step_x(step_x),
    .step_recip(step_recip), .step_res(step_res),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flag(out_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] newton(input logic [31:0] s, input logic [31:0] x,
                                         input logic [31:0] r);
    return ((s == 32'h4180_0000) ? x : x + 32'd1) + (r ^ ~x);
  endfunction

  // Responders, evaluated on the falling edge so the DUT samples them at the next rise.
  initial begin
    recip_valid = 1'b0;
    recip_res   = 32'h1234_5678;
    step_res    = 32'hDEAD_BEEF;
  end

  always @(negedge clk) begin
    if (recip_start === 1'b1) begin
      if (rs_cnt == 0) first_den = recip_den;
      rs_cnt++;
      den_l = recip_den;
      pend = L;
      recip_valid = 1'b0;
    end else if (pend > 0) begin
      pend--;
      recip_valid = (pend == 0);
      if (pend == 0) recip_res = ~den_l;
    end else begin
      recip_valid = 1'b0;
      recip_res   = 32'h1234_5678;
    end
    if (step_en === 1'b1) begin
      step_res  = newton(step_s, step_x, step_recip);
      step_hold = 1;
    end else if (step_hold) begin
      step_hold = 0;
    end else begin
      step_res = 32'hDEAD_BEEF;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] d, input logic [31:0] exp_d,
                        input logic [1:0] exp_f, input int exp_lat, input int hold);
    int n;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    in_data  = d;
    in_valid = 1'b1;
    rs_cnt   = 0;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 32'hFFFF_FFFF;
    n = 1;
    while (out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(exp_lat));
    chk("out_data", out_data, exp_d);
    chk("out_flag", 32'(out_flag), 32'(exp_f));
    chk("busy_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      in_data  = 32'h4000_0000;
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", out_data, exp_d);
      chk("hold_flag", 32'(out_flag), 32'(exp_f));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_out_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] ops [3];
    logic [31:0] b2b_exp [3];
    int acc, res, rdy, bad;

    // Reset held with both handshakes asserted: reset must win.
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h4180_0000; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_flag", 32'(out_flag), 32'd0);
    chk("rst_recip_start", 32'(recip_start), 32'd0);
    chk("rst_step_en", 32'(step_en), 32'd0);
    @(negedge clk);
    chk("rst_no_start", 32'(recip_start), 32'd0);
    chk("rst_still_idle", 32'(in_ready), 32'd1);

    // 16.0 -> 4.0 at cycle 17, held 5 cycles with in_valid pulses.
    run_op(32'h4180_0000, 32'h4080_0000, 2'b00, 17, 5);
    chk("recip_pulses_16", 32'(rs_cnt), 32'd3);

    // Negative unbiased exponents exercise the arithmetic shift.
    run_op(32'h3E80_0000, 32'h3F00_0003, 2'b00, 17, 0);
    chk("seed_0p25", first_den, 32'h3F00_0000);
    run_op(32'h3E00_0000, 32'h3E80_0003, 2'b00, 17, 0);
    chk("seed_0p125", first_den, 32'h3E80_0000);

`ifdef SQRT_ITER_CTRL_BYPASS_EN
    run_op(32'h8000_0000, 32'h8000_0000, 2'b01, 2, 0);
    run_op(32'hC000_0000, 32'h7FC0_0000, 2'b10, 2, 0);
    run_op(32'h7F80_0000, 32'h7F80_0000, 2'b00, 2, 0);
    run_op(32'h7FC0_0001, 32'h7FC0_0000, 2'b10, 2, 0);
    chk("bypass_no_recip", 32'(rs_cnt), 32'd0);
`else
    run_op(32'hC000_0000, 32'h3F80_0003, 2'b00, 17, 0);
    chk("neg_recip_pulses", 32'(rs_cnt), 32'd3);
    run_op(32'h0000_0000, 32'h1F80_0003, 2'b00, 17, 0);
`endif

    // Reset in the second RECIP cycle; the late recip_valid must be ignored.
    @(negedge clk);
    in_data = 32'h4180_0000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_first_recip", 32'(recip_start), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || recip_start !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    chk("abort_quiet", 32'(bad), 32'd0);
    run_op(32'h4180_0000, 32'h4080_0000, 2'b00, 17, 0);

    // Back-to-back with in_valid and out_ready held high.
    ops[0] = 32'h4180_0000; b2b_exp[0] = 32'h4080_0000;
    ops[1] = 32'h3E80_0000; b2b_exp[1] = 32'h3F00_0003;
    ops[2] = 32'h3E00_0000; b2b_exp[2] = 32'h3E80_0003;
    acc = 0; res = 0; rdy = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && res < 3; cyc++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        chk("b2b_data", out_data, b2b_exp[res]);
        res++;
      end
      if (in_ready === 1'b1) rdy++;
      if (acc < 3) begin
        in_data  = ops[acc];
        in_valid = 1'b1;
        if (in_ready === 1'b1) acc++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_results", 32'(res), 32'd3);
    chk("b2b_ready_cycles", 32'(rdy), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
